div_clk_monitor: RTL and testbench
==================================

# div_clk_monitor

Downstream companion to the frequency divider. Samples the divided clock in the `clk` domain and emits a single-cycle `tick` on each rising edge. It measures the divided-clock period in `clk` cycles and checks it against the divisor that was programmed. The calculator datapath uses `tick` as its slow-step strobe; the status outputs report divider misconfiguration or a stalled divider.

## Interface
- `WIDTH`, 32: divisor and period width.
- `SYNC_STAGES`, 2: synchronizer depth on `div_clk`, legal range 2–4.
- `clk`  in  1: system clock, same clock that drives the divider.
- `reset`  in  1: asynchronous, active-high.
- `div_clk`  in  1: divided clock from the divider's `clk_out`, treated as asynchronous data.
- `expected`  in  WIDTH: programmed divisor, sampled on `start`.
- `start`  in  1: one-cycle pulse that arms the monitor.
- `stop`  in  1: one-cycle pulse that returns the monitor to IDLE.
- `tick`  out  1: one-cycle pulse per synchronized rising edge of `div_clk`, active in any state except IDLE.
- `period`  out  WIDTH: last measured period in `clk` cycles.
- `period_valid`  out  1: one-cycle pulse when `period` updates.
- `mismatch`  out  1: sticky; set when a measured period differs from the latched divisor.
- `timeout`  out  1: sticky; set when no edge arrives within 2×divisor cycles.
- `bad_cfg`  out  1: one-cycle pulse when `start` is rejected.
- `busy`  out  1: high in ARM or MEASURE.

## Operation
- Synchronizer: `SYNC_STAGES` flops feed one extra edge-detect flop. Rising edge is `sync_last & ~edge_q`.
- States:
  - IDLE: counter cleared, `tick` suppressed, `busy`=0.
  - ARM: waits for the first rising edge.
  - MEASURE: counts `clk` cycles between rising edges.
- IDLE→ARM on `start` with `expected` ≥ 2. On entry: latch `expected` into `exp_q`, clear `mismatch` and `timeout`, clear the counter.
- `start` with `expected` < 2 is rejected:
  - pulse `bad_cfg`, stay in IDLE;
  - divisor 1 cannot be resolved by sampling with `clk`.
- ARM→MEASURE on the first edge; counter loads 1.
- In MEASURE, each cycle without an edge increments the counter, which is WIDTH+1 bits.
- In MEASURE, on an edge:
  - `period` ← counter[WIDTH-1:0]; `period_valid` pulses;
  - `mismatch` sets if counter ≠ `exp_q`;
  - counter reloads 1;
  - the state stays MEASURE, so measurement is continuous.
- Timeout in ARM or MEASURE: counter reaches {`exp_q`,1'b0} (2×divisor, WIDTH+1 bit compare) with no edge.
  - Set `timeout` and go to IDLE.
  - In ARM the counter also increments, from 0.
- `stop` in any state forces IDLE. `mismatch` and `timeout` hold their values.
- `start` while `busy` re-arms: re-latches `expected`, clears the sticky flags, goes to ARM.
- Priority when events coincide: `stop` > `start` > timeout > edge.
  - An edge in the same cycle as `stop` or `start` does not produce `period_valid`.
  - It still produces `tick` if the state was not IDLE.
- The counter saturates and does not wrap. Timeout always fires before overflow, because 2×(2^WIDTH−1) fits in WIDTH+1 bits.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizer flops 0, `period` 0, `exp_q` 0.
- `tick` latency: SYNC_STAGES+1 `clk` cycles after `div_clk` is first sampled high.
- `period_valid` is coincident with `tick`.
- A correct divider with even divisor N yields `period` = N exactly.
- Odd N yields alternating N−1/N+1 or N, depending on the divider's duty cycle. The bench checks odd divisors only with a tolerance of ±1. The `mismatch` flag is exact.
- `bad_cfg` and `busy` are registered and appear one cycle after `start`.
- Reset mid-measurement:
  - clears everything asynchronously;
  - the first `tick` after release requires `start` and then a fresh edge.

## Structure
- Shared package (`div_pkg`):
  - state encoding `MON_IDLE`, `MON_ARM`, `MON_MEASURE`;
  - `DIV_MIN` = 2;
  - `WIDTH` default constant, shared with the divider.
- Sub-module `sync_edge_det`: parameterized `SYNC_STAGES`, outputs `rise`. Reusable by other slow-strobe consumers.
- Top level holds the FSM, counter, compare logic and sticky flags.

## Test plan
- Divisor 4 from a reference divider, `start` with `expected`=4: `period_valid` each 4 cycles, `period`=4, `mismatch`=0, `tick` count equals rising-edge count.
- Divisor 6, `start` with `expected`=8: first `period_valid` shows `period`=6 and `mismatch`=1; `mismatch` stays set after the flag condition clears.
- Hold `div_clk` low after `start` with `expected`=5: `timeout`=1 exactly 10 cycles after entering ARM, state IDLE, `busy`=0.
- `start` with `expected`=1 and then `expected`=0: `bad_cfg` pulses each time, `busy` stays 0, no `tick`.
- Assert `reset` mid-MEASURE with divisor 8: all outputs 0 immediately, no `tick` after release until a new `start` followed by an edge.
- `stop` and an edge in the same cycle, divisor 4: no `period_valid`, one `tick`, then IDLE with no further ticks.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg : constants and state encoding shared by the divider family |
// | rev 1.0                                                             |
// +----------------------------------------------------------------------+
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DIV_MIN       = 2;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_ARM     = 2'd1,
    MON_MEASURE = 2'd2
  } mon_state_e;

endpackage
`default_nettype wire

// File: rtl/div_clk_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_clk_monitor_if : control and status bundle of the clock monitor |
// | rev 1.0                                                             |
// +----------------------------------------------------------------------+
interface div_clk_monitor_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             div_clk;
  logic [WIDTH-1:0] expected;
  logic             start;
  logic             stop;
  logic             tick;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             mismatch;
  logic             timeout;
  logic             bad_cfg;
  logic             busy;

  modport master (
    output div_clk, expected, start, stop,
    input  tick, period, period_valid, mismatch, timeout, bad_cfg, busy
  );

  modport slave (
    input  div_clk, expected, start, stop,
    output tick, period, period_valid, mismatch, timeout, bad_cfg, busy
  );
endinterface
`default_nettype wire

// File: rtl/div_clk_monitor_sync_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_edge_det : multi-flop synchronizer with rising-edge detector    |
// | rev 1.0                                                             |
// +----------------------------------------------------------------------+
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic d_i,
  output logic      rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule
`default_nettype wire

// File: rtl/div_clk_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_clk_monitor : divided-clock tick generator and period checker   |
// | rev 1.0                                                             |
// +----------------------------------------------------------------------+
module div_clk_monitor
  import div_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  div_clk_monitor_if.slave mon
);

  mon_state_e       state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             tick_q, tick_d;
  logic             pv_q, pv_d;
  logic             mm_q, mm_d;
  logic             to_q, to_d;
  logic             bad_q, bad_d;
  logic             busy_q, busy_d;
  logic             rise;
  logic             cfg_ok;
  logic             limit_hit;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (mon.div_clk),
    .rise_o (rise)
  );

  assign cfg_ok    = (mon.expected >= WIDTH'(DIV_MIN));
  // Saturating increment; the timeout limit is always reached first.
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign limit_hit = (cnt_inc == {exp_q, 1'b0});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    period_d = period_q;
    pv_d     = 1'b0;
    mm_d     = mm_q;
    to_d     = to_q;
    bad_d    = 1'b0;
    tick_d   = rise && (state_q != MON_IDLE);

    if (mon.stop) begin
      state_d = MON_IDLE;
      cnt_d   = '0;
    end else if (mon.start && cfg_ok) begin
      state_d = MON_ARM;
      exp_d   = mon.expected;
      mm_d    = 1'b0;
      to_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      bad_d = mon.start;
      unique case (state_q)
        MON_ARM, MON_MEASURE: begin
          if (limit_hit) begin
            to_d    = 1'b1;
            state_d = MON_IDLE;
            cnt_d   = '0;
          end else if (rise) begin
            if (state_q == MON_MEASURE) begin
              period_d = cnt_q[WIDTH-1:0];
              pv_d     = 1'b1;
              if (cnt_q != {1'b0, exp_q}) mm_d = 1'b1;
            end
            state_d = MON_MEASURE;
            cnt_d   = {{WIDTH{1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: cnt_d = '0;
      endcase
    end

    busy_d = (state_d != MON_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MON_IDLE;
      cnt_q    <= '0;
      exp_q    <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
      pv_q     <= 1'b0;
      mm_q     <= 1'b0;
      to_q     <= 1'b0;
      bad_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      pv_q     <= pv_d;
      mm_q     <= mm_d;
      to_q     <= to_d;
      bad_q    <= bad_d;
      busy_q   <= busy_d;
    end
  end

  assign mon.tick         = tick_q;
  assign mon.period       = period_q;
  assign mon.period_valid = pv_q;
  assign mon.mismatch     = mm_q;
  assign mon.timeout      = to_q;
  assign mon.bad_cfg      = bad_q;
  assign mon.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_clk_monitor : directed bench with a reference clock divider   |
// | rev 1.0                                                             |
// +----------------------------------------------------------------------+
module tb_div_clk_monitor;

  logic clk;
  logic reset;

  div_clk_monitor_if #(.WIDTH(32)) mon_if ();

  div_clk_monitor #(
    .WIDTH       (32),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference divider: rises when its phase counter wraps to 0.
  logic div_en = 1'b0;
  int   div_n  = 4;
  int   div_cnt = 0;
  int   edge_cnt = 0;

  always @(negedge clk) begin
    if (!div_en) begin
      div_cnt        = div_n - 1;
      mon_if.div_clk = 1'b0;
    end else begin
      div_cnt = (div_cnt >= div_n - 1) ? 0 : div_cnt + 1;
      if (div_cnt == 0) edge_cnt++;
      mon_if.div_clk = (div_cnt < div_n / 2);
    end
  end

  int          cyc = 0;
  int          tick_cnt = 0;
  int          pv_cnt = 0;
  int          pv_last = 0;
  int          pv_gap = 0;
  logic [31:0] last_period = '0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_if.tick) tick_cnt++;
    if (mon_if.period_valid) begin
      pv_cnt++;
      last_period = mon_if.period;
      pv_gap      = cyc - pv_last;
      pv_last     = cyc;
    end
  end

  task automatic start_pulse(input logic [31:0] val);
    mon_if.expected = val;
    mon_if.start    = 1'b1;
    @(negedge clk);
    mon_if.start    = 1'b0;
  endtask

  int e0, t0, p0;
  bit got_it;

  initial begin
    reset           = 1'b1;
    mon_if.start    = 1'b0;
    mon_if.stop     = 1'b0;
    mon_if.expected = '0;
    repeat (3) @(negedge clk);
    check("rst_tick",     mon_if.tick, 0);
    check("rst_period",   mon_if.period, 0);
    check("rst_pv",       mon_if.period_valid, 0);
    check("rst_mismatch", mon_if.mismatch, 0);
    check("rst_timeout",  mon_if.timeout, 0);
    check("rst_badcfg",   mon_if.bad_cfg, 0);
    check("rst_busy",     mon_if.busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Divisor 4, matching programmed value.
    start_pulse(32'd4);
    check("t1_busy", mon_if.busy, 1);
    e0 = edge_cnt; t0 = tick_cnt; p0 = pv_cnt;
    div_n = 4; div_en = 1'b1;
    repeat (10) @(posedge mon_if.div_clk);
    @(negedge clk) div_en = 1'b0;
    repeat (30) @(negedge clk);
    check("t1_ticks",    tick_cnt - t0, edge_cnt - e0);
    check("t1_pv_cnt",   pv_cnt - p0, 9);
    check("t1_period",   last_period, 4);
    check("t1_pv_gap",   pv_gap, 4);
    check("t1_mismatch", mon_if.mismatch, 0);
    check("t1_timeout",  mon_if.timeout, 1);
    check("t1_idle",     mon_if.busy, 0);

    // Divisor 6 against programmed 8; mismatch must stay sticky.
    @(negedge clk);
    start_pulse(32'd8);
    check("t2_to_clr", mon_if.timeout, 0);
    p0 = pv_cnt;
    div_n = 6; div_en = 1'b1;
    got_it = 0;
    for (int i = 0; i < 100 && !got_it; i++) begin
      @(negedge clk);
      if (pv_cnt != p0) got_it = 1;
    end
    check("t2_pv_seen",  got_it, 1);
    check("t2_period",   last_period, 6);
    check("t2_mismatch", mon_if.mismatch, 1);
    div_n = 8;
    p0 = pv_cnt;
    got_it = 0;
    for (int i = 0; i < 200 && !got_it; i++) begin
      @(negedge clk);
      if (pv_cnt - p0 >= 3) got_it = 1;
    end
    check("t2_pv_more",    got_it, 1);
    check("t2_period8",    last_period, 8);
    check("t2_mm_sticky",  mon_if.mismatch, 1);
    check("t2_busy",       mon_if.busy, 1);
    div_en = 1'b0;
    repeat (40) @(negedge clk);

    // Timeout with expected 5 and div_clk held low.
    start_pulse(32'd5);
    check("t3_busy", mon_if.busy, 1);
    repeat (9) @(negedge clk);
    check("t3_no_to_yet", mon_if.timeout, 0);
    check("t3_busy_pre",  mon_if.busy, 1);
    @(negedge clk);
    check("t3_timeout",   mon_if.timeout, 1);
    check("t3_idle",      mon_if.busy, 0);

    // Rejected configurations while the divider runs.
    div_n = 4; div_en = 1'b1;
    repeat (5) @(negedge clk);
    t0 = tick_cnt;
    start_pulse(32'd1);
    check("t4_bad1",      mon_if.bad_cfg, 1);
    check("t4_busy1",     mon_if.busy, 0);
    @(negedge clk);
    check("t4_bad1_end",  mon_if.bad_cfg, 0);
    start_pulse(32'd0);
    check("t4_bad0",      mon_if.bad_cfg, 1);
    check("t4_busy0",     mon_if.busy, 0);
    @(negedge clk);
    check("t4_bad0_end",  mon_if.bad_cfg, 0);
    repeat (20) @(negedge clk);
    check("t4_no_tick",   tick_cnt - t0, 0);
    div_en = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-measurement, divisor 8.
    start_pulse(32'd8);
    div_n = 8; div_en = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_pre_period", mon_if.period, 8);
    #2 reset = 1'b1;
    #1;
    check("t5_period", mon_if.period, 0);
    check("t5_busy",   mon_if.busy, 0);
    check("t5_tick",   mon_if.tick, 0);
    check("t5_pv",     mon_if.period_valid, 0);
    check("t5_mm",     mon_if.mismatch, 0);
    check("t5_to",     mon_if.timeout, 0);
    @(negedge clk) reset = 1'b0;
    t0 = tick_cnt;
    repeat (40) @(negedge clk);
    check("t5_no_tick", tick_cnt - t0, 0);
    start_pulse(32'd8);
    got_it = 0;
    for (int i = 0; i < 40 && !got_it; i++) begin
      @(negedge clk);
      if (tick_cnt != t0) got_it = 1;
    end
    check("t5_tick_after_start", got_it, 1);
    div_en = 1'b0;
    repeat (30) @(negedge clk);

    // stop coincident with a synchronized edge, divisor 4.
    start_pulse(32'd4);
    div_n = 4; div_en = 1'b1;
    repeat (3) @(posedge mon_if.div_clk);
    repeat (2) @(negedge clk);
    mon_if.stop = 1'b1;
    t0 = tick_cnt; p0 = pv_cnt;
    @(negedge clk);
    mon_if.stop = 1'b0;
    check("t6_tick",     mon_if.tick, 1);
    check("t6_pv",       mon_if.period_valid, 0);
    check("t6_tick_cnt", tick_cnt - t0, 1);
    check("t6_pv_cnt",   pv_cnt - p0, 0);
    check("t6_idle",     mon_if.busy, 0);
    repeat (20) @(negedge clk);
    check("t6_no_more",  tick_cnt - t0, 1);
    div_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
